// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at issue, captures CDB results,
// answers operand lookups and retires one instruction per cycle in program order.
module reorder_buffer #(
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [1:0]       issue_type,
  input  logic [4:0]       issue_rd,
  input  logic [31:0]      issue_pc,
  input  logic             issue_pred_jump,
  input  logic             issue_ready,
  input  logic [31:0]      issue_value,
  output logic             rob_full,
  output logic [ROB_W-1:0] issue_rob_id,
  output logic             need_set_reg_dep,
  output logic [4:0]       set_dep_reg_id,
  output logic [ROB_W-1:0] set_dep_rob_id,
  input  logic             wb_valid,
  input  logic [ROB_W-1:0] wb_rob_id,
  input  logic [31:0]      wb_value,
  input  logic             wb_real_jump,
  input  logic [31:0]      wb_target,
  input  logic [ROB_W-1:0] need_rob_id1,
  input  logic [ROB_W-1:0] need_rob_id2,
  output logic             rob_value1_ready,
  output logic [31:0]      rob_value1,
  output logic             rob_value2_ready,
  output logic [31:0]      rob_value2,
  output logic             need_set_reg_value,
  output logic [4:0]       set_value_reg_id,
  output logic [31:0]      set_val,
  output logic [ROB_W-1:0] set_reg_rob_id,
  output logic             store_commit,
  output logic [ROB_W-1:0] store_commit_rob_id,
  output logic             clear,
  output logic [31:0]      clear_pc,
  output logic             halt
);

  localparam int DEPTH = 1 << ROB_W;
  localparam logic [1:0] T_REG    = 2'd0;
  localparam logic [1:0] T_STORE  = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;
  localparam logic [1:0] T_EXIT   = 2'd3;

  logic [ROB_W-1:0] r_head;
  logic [ROB_W-1:0] r_tail;
  logic [ROB_W:0]   r_count;
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] r_ready;
  logic [DEPTH-1:0] r_pred;
  logic [DEPTH-1:0] r_real_jump;
  logic [1:0]       r_type   [DEPTH];
  logic [4:0]       r_rd     [DEPTH];
  logic [31:0]      r_pc     [DEPTH];
  logic [31:0]      r_value  [DEPTH];
  logic [31:0]      r_target [DEPTH];

  logic             w_retire;
  logic             w_accept;
  logic             w_mispredict;
  logic             w_flush;
  logic             w_wb;
  logic             w_writes_rd;
  logic [ROB_W:0]   w_count_nxt;

  assign rob_full     = (r_count == (ROB_W+1)'(DEPTH));
  assign w_retire     = rdy & ~clear & ~halt & r_busy[r_head] & r_ready[r_head];
  // A full buffer may still take an issue on the edge its head retires: the
  // freed head slot is exactly the tail slot.
  assign w_accept     = rdy & issue_valid & ~clear & (~rob_full | w_retire);
  assign w_mispredict = w_retire & (r_type[r_head] == T_BRANCH) &
                        (r_real_jump[r_head] != r_pred[r_head]);
  assign w_flush      = rdy & (clear | w_mispredict);
  assign w_wb         = rdy & wb_valid & r_busy[wb_rob_id] & ~w_flush &
                        ~(w_retire & (wb_rob_id == r_head));
  assign w_writes_rd  = (r_rd[r_head] != 5'd0) &
                        ((r_type[r_head] == T_REG) | (r_type[r_head] == T_BRANCH));
  assign w_count_nxt  = r_count + (ROB_W+1)'(w_accept) - (ROB_W+1)'(w_retire);

  assign issue_rob_id     = r_tail;
  assign need_set_reg_dep = w_accept & (issue_rd != 5'd0) &
                            ((issue_type == T_REG) | (issue_type == T_BRANCH));
  assign set_dep_reg_id   = issue_rd;
  assign set_dep_rob_id   = r_tail;

  // Operand lookup with same-cycle CDB bypass.
  always_comb begin
    rob_value1_ready = r_ready[need_rob_id1];
    rob_value1       = r_value[need_rob_id1];
    rob_value2_ready = r_ready[need_rob_id2];
    rob_value2       = r_value[need_rob_id2];
    if (wb_valid && (wb_rob_id == need_rob_id1)) begin
      rob_value1_ready = 1'b1;
      rob_value1       = wb_value;
    end
    if (wb_valid && (wb_rob_id == need_rob_id2)) begin
      rob_value2_ready = 1'b1;
      rob_value2       = wb_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head              <= '0;
      r_tail              <= '0;
      r_count             <= '0;
      r_busy              <= '0;
      r_ready             <= '0;
      r_pred              <= '0;
      r_real_jump         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_type[i]   <= '0;
        r_rd[i]     <= '0;
        r_pc[i]     <= '0;
        r_value[i]  <= '0;
        r_target[i] <= '0;
      end
      need_set_reg_value  <= 1'b0;
      set_value_reg_id    <= '0;
      set_val             <= '0;
      set_reg_rob_id      <= '0;
      store_commit        <= 1'b0;
      store_commit_rob_id <= '0;
      clear               <= 1'b0;
      clear_pc            <= '0;
      halt                <= 1'b0;
    end else if (!rdy) begin
      need_set_reg_value <= 1'b0;
      store_commit       <= 1'b0;
      clear              <= 1'b0;
    end else begin
      need_set_reg_value <= 1'b0;
      store_commit       <= 1'b0;
      clear              <= 1'b0;

      if (w_retire) begin
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= r_head + ROB_W'(1);
        if (w_writes_rd) begin
          need_set_reg_value <= 1'b1;
          set_value_reg_id   <= r_rd[r_head];
          set_val            <= r_value[r_head];
          set_reg_rob_id     <= r_head;
        end
        if (r_type[r_head] == T_STORE) begin
          store_commit        <= 1'b1;
          store_commit_rob_id <= r_head;
        end
        if (r_type[r_head] == T_EXIT) begin
          halt <= 1'b1;
        end
        if (w_mispredict) begin
          clear    <= 1'b1;
          clear_pc <= r_real_jump[r_head] ? r_target[r_head] : r_pc[r_head] + 32'd4;
        end
      end

      if (w_wb) begin
        r_ready[wb_rob_id]     <= 1'b1;
        r_value[wb_rob_id]     <= wb_value;
        r_real_jump[wb_rob_id] <= wb_real_jump;
        r_target[wb_rob_id]    <= wb_target;
      end

      if (w_accept && !w_flush) begin
        r_busy[r_tail]      <= 1'b1;
        r_ready[r_tail]     <= issue_ready;
        r_type[r_tail]      <= issue_type;
        r_rd[r_tail]        <= issue_rd;
        r_pc[r_tail]        <= issue_pc;
        r_pred[r_tail]      <= issue_pred_jump;
        r_value[r_tail]     <= issue_value;
        r_real_jump[r_tail] <= 1'b0;
        r_target[r_tail]    <= '0;
        r_tail              <= r_tail + ROB_W'(1);
      end

      // Mispredict drops every younger entry at once; the clear cycle repeats it.
      if (w_flush) begin
        r_busy  <= '0;
        r_ready <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_count <= w_count_nxt;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus pushes expected retire pulses into
// queues, a negedge monitor pops and compares whenever a pulse appears.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue_valid, issue_pred_jump, issue_ready;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc, issue_value;
  logic        rob_full, need_set_reg_dep;
  logic [3:0]  issue_rob_id, set_dep_rob_id;
  logic [4:0]  set_dep_reg_id;
  logic        wb_valid, wb_real_jump;
  logic [3:0]  wb_rob_id, need_rob_id1, need_rob_id2;
  logic [31:0] wb_value, wb_target;
  logic        rob_value1_ready, rob_value2_ready;
  logic [31:0] rob_value1, rob_value2;
  logic        need_set_reg_value, store_commit, clear, halt;
  logic [4:0]  set_value_reg_id;
  logic [31:0] set_val, clear_pc;
  logic [3:0]  set_reg_rob_id, store_commit_rob_id;

  int checks = 0;
  int errors = 0;

  logic [40:0] exp_reg_q[$];
  logic [3:0]  exp_st_q[$];
  logic [31:0] exp_clr_q[$];

  reorder_buffer #(.ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump),
    .issue_ready(issue_ready), .issue_value(issue_value),
    .rob_full(rob_full), .issue_rob_id(issue_rob_id),
    .need_set_reg_dep(need_set_reg_dep), .set_dep_reg_id(set_dep_reg_id),
    .set_dep_rob_id(set_dep_rob_id),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .wb_real_jump(wb_real_jump), .wb_target(wb_target),
    .need_rob_id1(need_rob_id1), .need_rob_id2(need_rob_id2),
    .rob_value1_ready(rob_value1_ready), .rob_value1(rob_value1),
    .rob_value2_ready(rob_value2_ready), .rob_value2(rob_value2),
    .need_set_reg_value(need_set_reg_value), .set_value_reg_id(set_value_reg_id),
    .set_val(set_val), .set_reg_rob_id(set_reg_rob_id),
    .store_commit(store_commit), .store_commit_rob_id(store_commit_rob_id),
    .clear(clear), .clear_pc(clear_pc), .halt(halt)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b1;
    issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0; issue_pc = 32'd0;
    issue_pred_jump = 1'b0; issue_ready = 1'b0; issue_value = 32'd0;
    wb_valid = 1'b0; wb_rob_id = 4'd0; wb_value = 32'd0;
    wb_real_jump = 1'b0; wb_target = 32'd0;
    need_rob_id1 = 4'd0; need_rob_id2 = 4'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Driver tasks
  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                       input logic pj, input logic ir, input logic [31:0] iv,
                       input logic exp_dep, input logic [3:0] exp_tag);
    issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pc = pc;
    issue_pred_jump = pj; issue_ready = ir; issue_value = iv;
    #1;
    chk("issue_rob_id", 32'(issue_rob_id), 32'(exp_tag));
    chk("need_set_reg_dep", 32'(need_set_reg_dep), 32'(exp_dep));
    if (exp_dep) begin
      chk("set_dep_reg_id", 32'(set_dep_reg_id), 32'(rd));
      chk("set_dep_rob_id", 32'(set_dep_rob_id), 32'(exp_tag));
    end
    tick();
    issue_valid = 1'b0;
    issue_ready = 1'b0;
  endtask

  task automatic wb(input logic [3:0] tag, input logic [31:0] val,
                    input logic rj, input logic [31:0] tgt);
    wb_valid = 1'b1; wb_rob_id = tag; wb_value = val;
    wb_real_jump = rj; wb_target = tgt;
    tick();
    wb_valid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (need_set_reg_value) begin
        checks++;
        if (exp_reg_q.size() == 0) begin
          errors++;
          $display("FAIL reg_pulse unexpected: rd=%0d val=%h tag=%0d",
                   set_value_reg_id, set_val, set_reg_rob_id);
        end else begin
          logic [40:0] e;
          e = exp_reg_q.pop_front();
          if ({set_value_reg_id, set_val, set_reg_rob_id} !== e) begin
            errors++;
            $display("FAIL reg_pulse: got %h expected %h",
                     {set_value_reg_id, set_val, set_reg_rob_id}, e);
          end
        end
      end
      if (store_commit) begin
        checks++;
        if (exp_st_q.size() == 0) begin
          errors++;
          $display("FAIL store_commit unexpected: tag=%0d", store_commit_rob_id);
        end else begin
          logic [3:0] s;
          s = exp_st_q.pop_front();
          if (store_commit_rob_id !== s) begin
            errors++;
            $display("FAIL store_commit_rob_id: got %0d expected %0d", store_commit_rob_id, s);
          end
        end
      end
      if (clear) begin
        checks++;
        if (exp_clr_q.size() == 0) begin
          errors++;
          $display("FAIL clear unexpected: clear_pc=%h", clear_pc);
        end else begin
          logic [31:0] c;
          c = exp_clr_q.pop_front();
          if (clear_pc !== c) begin
            errors++;
            $display("FAIL clear_pc: got %h expected %h", clear_pc, c);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    // Reset state
    do_reset();
    chk("reset rob_full", 32'(rob_full), 0);
    chk("reset issue_rob_id", 32'(issue_rob_id), 0);
    chk("reset need_set_reg_value", 32'(need_set_reg_value), 0);
    chk("reset store_commit", 32'(store_commit), 0);
    chk("reset clear", 32'(clear), 0);
    chk("reset clear_pc", clear_pc, 0);
    chk("reset halt", 32'(halt), 0);
    chk("reset set_val", set_val, 0);

    // 1: basic issue, writeback, retire
    issue(2'd0, 5'd5, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0);
    exp_reg_q.push_back({5'd5, 32'h1234, 4'd0});
    wb(4'd0, 32'h1234, 1'b0, 32'h0);
    repeat (3) tick();

    // 2: fill to full, reject, then reuse the retiring slot
    do_reset();
    for (int i = 0; i < 16; i++)
      issue(2'd0, 5'(i + 1), 32'(i * 4), 1'b0, 1'b0, 32'h0, 1'b1, 4'(i));
    chk("full after 16", 32'(rob_full), 1);
    issue(2'd0, 5'd17, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0);
    chk("full after rejected issue", 32'(rob_full), 1);
    exp_reg_q.push_back({5'd1, 32'h0000_00A0, 4'd0});
    wb(4'd0, 32'hA0, 1'b0, 32'h0);
    issue(2'd0, 5'd20, 32'h44, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0);
    chk("full after issue+retire", 32'(rob_full), 1);
    chk("tail after wrap", 32'(issue_rob_id), 1);
    repeat (2) tick();

    // 3: lookup with same-cycle CDB bypass
    do_reset();
    for (int i = 0; i < 4; i++)
      issue(2'd0, 5'(i + 1), 32'(i * 4), 1'b0, 1'b0, 32'h0, 1'b1, 4'(i));
    need_rob_id1 = 4'd3; need_rob_id2 = 4'd2;
    #1;
    chk("lookup1 ready before wb", 32'(rob_value1_ready), 0);
    wb_valid = 1'b1; wb_rob_id = 4'd3; wb_value = 32'hAB;
    #1;
    chk("bypass ready1", 32'(rob_value1_ready), 1);
    chk("bypass value1", rob_value1, 32'hAB);
    chk("lookup2 not ready", 32'(rob_value2_ready), 0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("stored ready1", 32'(rob_value1_ready), 1);
    chk("stored value1", rob_value1, 32'hAB);

    // 4: branch mispredict with rd link, flush of younger entries
    do_reset();
    issue(2'd2, 5'd4, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0);
    issue(2'd0, 5'd7, 32'h104, 1'b0, 1'b0, 32'h0, 1'b1, 4'd1);
    exp_reg_q.push_back({5'd4, 32'h104, 4'd0});
    exp_clr_q.push_back(32'h200);
    wb(4'd0, 32'h104, 1'b1, 32'h200);
    tick();
    chk("clear high", 32'(clear), 1);
    issue(2'd0, 5'd8, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0);
    chk("clear one cycle", 32'(clear), 0);
    issue(2'd0, 5'd9, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0);
    wb(4'd1, 32'h77, 1'b0, 32'h0);
    need_rob_id1 = 4'd1;
    #1;
    chk("flushed entry not ready", 32'(rob_value1_ready), 0);
    exp_reg_q.push_back({5'd9, 32'h99, 4'd0});
    wb(4'd0, 32'h99, 1'b0, 32'h0);
    repeat (3) tick();

    // 5: store commit, rd=0 retires silently
    do_reset();
    issue(2'd1, 5'd3, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0);
    issue(2'd0, 5'd0, 32'h304, 1'b0, 1'b0, 32'h0, 1'b0, 4'd1);
    exp_st_q.push_back(4'd0);
    wb(4'd0, 32'h0, 1'b0, 32'h0);
    wb(4'd1, 32'h55, 1'b0, 32'h0);
    repeat (4) tick();
    chk("tail after store test", 32'(issue_rob_id), 2);

    // 6: rdy freeze mid-retire
    do_reset();
    exp_reg_q.push_back({5'd10, 32'h10, 4'd0});
    exp_reg_q.push_back({5'd11, 32'h11, 4'd1});
    exp_reg_q.push_back({5'd12, 32'h12, 4'd2});
    issue(2'd0, 5'd10, 32'h400, 1'b0, 1'b1, 32'h10, 1'b1, 4'd0);
    issue(2'd0, 5'd11, 32'h404, 1'b0, 1'b1, 32'h11, 1'b1, 4'd1);
    issue(2'd0, 5'd12, 32'h408, 1'b0, 1'b1, 32'h12, 1'b1, 4'd2);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frozen no reg pulse", 32'(need_set_reg_value), 0);
      chk("frozen tail", 32'(issue_rob_id), 3);
    end
    rdy = 1'b1;
    exp_reg_q.push_back({5'd13, 32'h13, 4'd3});
    issue(2'd0, 5'd13, 32'h40C, 1'b0, 1'b1, 32'h13, 1'b1, 4'd3);
    repeat (4) tick();

    // Correct prediction, then EXIT halts retirement
    do_reset();
    issue(2'd2, 5'd2, 32'h40, 1'b1, 1'b0, 32'h0, 1'b1, 4'd0);
    issue(2'd3, 5'd0, 32'h44, 1'b0, 1'b1, 32'h0, 1'b0, 4'd1);
    issue(2'd0, 5'd1, 32'h48, 1'b0, 1'b1, 32'h5, 1'b1, 4'd2);
    exp_reg_q.push_back({5'd2, 32'h44, 4'd0});
    wb(4'd0, 32'h44, 1'b1, 32'h80);
    repeat (5) tick();
    chk("halt sticky", 32'(halt), 1);
    do_reset();
    chk("halt cleared by reset", 32'(halt), 0);

    // Drain with a bounded wait, then report
    for (int i = 0; i < 20; i++) begin
      if (exp_reg_q.size() == 0 && exp_st_q.size() == 0 && exp_clr_q.size() == 0) break;
      tick();
    end
    chk("reg queue drained", 32'(exp_reg_q.size()), 0);
    chk("store queue drained", 32'(exp_st_q.size()), 0);
    chk("clear queue drained", 32'(exp_clr_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
